// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: funct3 size codes, FSM state
// encoding and the access-alignment predicate.
// Exports: F3_* constants, state_e, is_misaligned().
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // size is funct3[1:0]; any code other than byte/half (incl. 011) is a word.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] off);
    logic mis;
    case (size)
      F3_B[1:0]: mis = 1'b0;
      F3_H[1:0]: mis = off[0];
      default:   mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the memory stage.
// Store side: replicates store data across byte lanes and builds the strobes.
// Load side: selects the addressed lane of the RAM word and sign/zero-extends.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size_i,   // store funct3[1:0]
  input  logic [1:0]  st_off_i,    // store byte offset
  input  logic [31:0] st_data_i,   // rs2 value
  output logic [31:0] st_wdata_o,  // lane-replicated data
  output logic [3:0]  st_wstrb_o,  // byte strobes
  input  logic [2:0]  ld_funct3_i, // load funct3 (bit 2 = unsigned)
  input  logic [1:0]  ld_off_i,    // load byte offset
  input  logic [31:0] ld_rdata_i,  // RAM read word
  output logic [31:0] ld_value_o   // extended load value
);

  logic [31:0] shifted;
  logic        sign_ext;

  always_comb begin
    st_wdata_o = st_data_i;
    st_wstrb_o = 4'b1111;
    case (st_size_i)
      F3_B[1:0]: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_wstrb_o = 4'b0001 << st_off_i;
      end
      F3_H[1:0]: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_wstrb_o = 4'b0011 << st_off_i;
      end
      default: begin
        st_wdata_o = st_data_i;
        st_wstrb_o = 4'b1111;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0 before extension.
  assign shifted  = ld_rdata_i >> {ld_off_i, 3'b000};
  assign sign_ext = ~ld_funct3_i[2];

  always_comb begin
    ld_value_o = ld_rdata_i;
    case (ld_funct3_i[1:0])
      F3_B[1:0]: ld_value_o = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      F3_H[1:0]: ld_value_o = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      default:   ld_value_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// CPU memory stage: accepts execute results, performs loads/stores on the data
// RAM via a valid/ready request, and retires a registered result to writeback.
// Ports: in_valid/result/store_data/rd/reg_write/mem_read/mem_write/funct3 from
// execute; stall upstream; mem_* RAM port; wb_* registered retirement outputs.
module memory_stage
  import mem_pkg::*;
#(
  parameter int RAM_AW = 10,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [XLEN-1:0]   result,
  input  logic [XLEN-1:0]   store_data,
  input  logic [4:0]        rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [RAM_AW-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ready,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_value,
  output logic              wb_reg_write,
  output logic              wb_misaligned
);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [RAM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wstrb_q, mem_wstrb_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_value_q, wb_value_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              wb_misaligned_q, wb_misaligned_d;
  // Pending-access context
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              regw_q, regw_d;

  logic [XLEN-1:0]   st_wdata;
  logic [3:0]        st_wstrb;
  logic [XLEN-1:0]   ld_value;
  logic              is_mem;
  logic              unused_addr_bits;

  // Address bits above the RAM window are not decoded here.
  assign unused_addr_bits = ^result[XLEN-1:RAM_AW+2];

  assign is_mem = mem_read | mem_write;

  mem_align u_align (
    .st_size_i   (funct3[1:0]),
    .st_off_i    (result[1:0]),
    .st_data_i   (store_data),
    .st_wdata_o  (st_wdata),
    .st_wstrb_o  (st_wstrb),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (mem_rdata),
    .ld_value_o  (ld_value)
  );

  always_comb begin
    state_d         = state_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wstrb_d     = mem_wstrb_q;
    wb_valid_d      = 1'b0;
    wb_rd_d         = wb_rd_q;
    wb_value_d      = wb_value_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_misaligned_d = wb_misaligned_q;
    rd_d            = rd_q;
    f3_d            = f3_q;
    off_d           = off_q;
    regw_d          = regw_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_valid_d      = 1'b1;
            wb_rd_d         = rd;
            wb_value_d      = result;
            wb_reg_write_d  = reg_write && (rd != 5'd0);
            wb_misaligned_d = 1'b0;
          end else if (is_misaligned(funct3[1:0], result[1:0])) begin
            // Retire immediately as a fault; the RAM never sees it.
            wb_valid_d      = 1'b1;
            wb_rd_d         = rd;
            wb_value_d      = result;
            wb_reg_write_d  = 1'b0;
            wb_misaligned_d = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            mem_req_d   = 1'b1;
            // A store wins when both read and write are flagged.
            mem_we_d    = mem_write;
            mem_addr_d  = result[RAM_AW+1:2];
            mem_wdata_d = st_wdata;
            mem_wstrb_d = mem_write ? st_wstrb : 4'b0000;
            rd_d        = rd;
            f3_d        = funct3;
            off_d       = result[1:0];
            regw_d      = reg_write;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ready) begin
          state_d         = ST_IDLE;
          mem_req_d       = 1'b0;
          wb_valid_d      = 1'b1;
          wb_rd_d         = rd_q;
          wb_misaligned_d = 1'b0;
          if (mem_we_q) begin
            wb_value_d     = '0;
            wb_reg_write_d = 1'b0;
          end else begin
            wb_value_d     = ld_value;
            wb_reg_write_d = regw_q && (rd_q != 5'd0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= 4'b0000;
      wb_valid_q      <= 1'b0;
      wb_rd_q         <= 5'd0;
      wb_value_q      <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_misaligned_q <= 1'b0;
      rd_q            <= 5'd0;
      f3_q            <= 3'd0;
      off_q           <= 2'd0;
      regw_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wstrb_q     <= mem_wstrb_d;
      wb_valid_q      <= wb_valid_d;
      wb_rd_q         <= wb_rd_d;
      wb_value_q      <= wb_value_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_misaligned_q <= wb_misaligned_d;
      rd_q            <= rd_d;
      f3_q            <= f3_d;
      off_q           <= off_d;
      regw_q          <= regw_d;
    end
  end

  assign stall         = (state_q == ST_ACCESS);
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_value      = wb_value_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_misaligned = wb_misaligned_q;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Fourth pipeline stage of the CPU, directly downstream of execute. It consumes the execute result, store data and control, and performs loads and stores against the data RAM through a valid/ready request port. It handles byte, halfword and word sizes with alignment checking, and sign- or zero-extends load data. It presents a registered result to writeback and stalls upstream while a RAM access is outstanding.

Parameters:
RAM_AW, 10, word-address width of the data RAM port.
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  stage clock
rst  in  1  synchronous active-high reset
in_valid  in  1  execute presents an operation this cycle
result  in  32  ALU result; byte address for memory ops
store_data  in  32  rs2 value for stores
rd  in  5  destination register
reg_write  in  1  operation writes rd
mem_read  in  1  load
mem_write  in  1  store
funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
stall  out  1  upstream must hold its outputs
mem_req  out  1  RAM request valid
mem_we  out  1  RAM write enable
mem_addr  out  RAM_AW  RAM word address, result[RAM_AW+1:2]
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte strobes
mem_rdata  in  32  RAM read word
mem_ready  in  1  RAM completes request this cycle
wb_valid  out  1  one-cycle pulse, operation retired
wb_rd  out  5  destination register
wb_value  out  32  load data or pass-through ALU result
wb_reg_write  out  1  writeback enable
wb_misaligned  out  1  retired op was a misaligned access

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state IDLE. stall, mem_req, mem_we, mem_wstrb, wb_valid, wb_reg_write and wb_misaligned are 0. mem_addr, mem_wdata, wb_rd and wb_value are 0.
- FSM states: IDLE, ACCESS. stall = (state == ACCESS), as a combinational function of registered state.
- IDLE with in_valid: the input is always accepted.
  - Non-memory op: at the next edge, wb_valid=1, wb_value=result, wb_rd=rd, wb_reg_write=reg_write && (rd != 0). Latency is 1.
  - Misaligned memory op (H/HU with addr[0]=1; W with addr[1:0]!=0): no RAM request. At the next edge, wb_valid=1, wb_misaligned=1, wb_reg_write=0.
  - Aligned memory op: at the next edge, go to ACCESS. Register mem_req=1, mem_we=mem_write, mem_addr, mem_wdata, mem_wstrb, and latch rd, funct3, addr[1:0] and reg_write.
  - If mem_read and mem_write are both set, the op is a store.
- Store data and strobes:
  - B: wdata = {4{sd[7:0]}}, wstrb = 0001 << addr[1:0].
  - H: wdata = {2{sd[15:0]}}, wstrb = 0011 << addr[1:0].
  - W: wdata = sd, wstrb = 1111.
  - Loads: wstrb = 0000.
- ACCESS: hold all mem_* outputs stable until mem_ready=1.
  - On the ready edge: mem_req=0, state IDLE, wb_valid=1.
  - Load: wb_value = the selected lane of mem_rdata, sign-extended for B/H and zero-extended for BU/HU. wb_reg_write=reg_write && (rd != 0).
  - Store: wb_reg_write=0 and wb_value=0.
  - Load latency is k+1 cycles after acceptance, where k≥1 is the cycle in which mem_ready is seen.
- mem_ready while in IDLE is ignored.
- wb_valid is 0 in every cycle in which no op retires. wb_* fields hold their last values while wb_valid=0.
- Back-to-back: an op presented on the ready edge's following IDLE cycle is accepted normally, giving one op per cycle for non-memory ops.
- Reset mid-ACCESS: at the reset edge return to IDLE, mem_req=0, and drop the pending op with no wb_valid. RAM must tolerate a withdrawn request.
- funct3 encodings 011, 110 and 111 on a memory op are treated as W.

Decomposition:
- Package mem_pkg: funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding (ST_IDLE, ST_ACCESS), and the misalignment predicate function.
- Sub-module mem_align (combinational): store lane replication and strobe generation, load lane select and extension. The parent holds the FSM and all registers.

Test Plan:
- Non-memory op: result=0x1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_value=0x1234, wb_rd=5, wb_reg_write=1, stall=0 throughout.
- SB sd=0xAABBCCDD at addr 0x103, RAM ready after 2 cycles -> mem_addr=0x40, mem_wdata=0xDDDDDDDD, mem_wstrb=1000, stall=1 for 2 cycles, then wb_valid=1 with wb_reg_write=0.
- LB at addr 0x2, mem_rdata=0x0080FF00, rd=7:
  - wb_value=0xFFFFFF80.
  - Repeat as LBU -> 0x00000080.
  - LHU at addr 0x2 -> 0x00000080; LH at addr 0x0 -> 0xFFFFFF00.
- LW at addr 0x6 -> no mem_req ever; next cycle wb_valid=1, wb_misaligned=1, wb_reg_write=0.
- LW to rd=0, RAM ready in 1 cycle -> access performed, wb_valid=1, wb_reg_write=0.
- Assert rst in the second ACCESS cycle of an LW -> next edge mem_req=0, stall=0, no wb_valid. A later mem_ready pulse produces no retirement.
